branch_resolver: RTL

Resolution end of the branch-prediction path. It records every prediction issued at decode, then retires those predictions in order as the corresponding control-flow instructions resolve in EX/MEM. It compares the predicted and actual outcomes, drives the front-end redirect and flush on a mispredict, and issues the training update back to the predictor over a ready/valid handshake. It sits between the decode-stage controller (the source of predictions) and the predictor's update port.

---
 rtl/br_pkg.sv | 27 ++
 rtl/br_inflight_fifo.sv | 69 ++++++
 rtl/branch_resolver.sv | 137 +++++++++++++
 3 files changed

// File: rtl/br_pkg.sv
// rtl/br_pkg.sv - shared types and constants for the branch resolution path
package br_pkg;

  localparam int unsigned PC_W_DEF  = 32;
  localparam int unsigned FLUSH_CYC = 2;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic                taken;
    logic [PC_W_DEF-1:0] pc;
    logic [PC_W_DEF-1:0] target;
  } br_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    F1   = 2'd1,
    F2   = 2'd2
  } flush_state_e;

  function automatic logic is_ctrl_flow(input logic [6:0] opcode);
    return (opcode == OPC_BRANCH) || (opcode == OPC_JAL) || (opcode == OPC_JALR);
  endfunction

endpackage

// File: rtl/br_inflight_fifo.sv
// rtl/br_inflight_fifo.sv - in-order queue of predictions awaiting resolution
module br_inflight_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            push_taken,
  input  logic [PC_W-1:0] push_pc,
  input  logic [PC_W-1:0] push_target,
  input  logic            pop,
  input  logic            clear,
  output logic            full,
  output logic            empty,
  output logic            head_taken,
  output logic [PC_W-1:0] head_pc,
  output logic [PC_W-1:0] head_target
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] taken_q;
  logic [PC_W-1:0]  pc_q     [DEPTH];
  logic [PC_W-1:0]  target_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head_taken  = taken_q[rd_ptr_q];
  assign head_pc     = pc_q[rd_ptr_q];
  assign head_target = target_q[rd_ptr_q];

  // Power-of-two DEPTH lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      taken_q[wr_ptr_q]  <= push_taken;
      pc_q[wr_ptr_q]     <= push_pc;
      target_q[wr_ptr_q] <= push_target;
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - retires predictions in order, redirects on mispredict, trains predictor
// Optional saturating statistics counters are built when BRANCH_RESOLVER_STATS_EN is defined.
module branch_resolver
  import br_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned UPD_AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pred_valid,
  input  logic              pred_taken,
  input  logic [PC_W-1:0]   pred_pc,
  input  logic [PC_W-1:0]   pred_target,
  input  logic              stall,
  output logic              full,
  input  logic              res_valid,
  input  logic              res_taken,
  input  logic [PC_W-1:0]   res_target,
  output logic              res_ready,
  output logic              redirect,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              flush,
  output logic              upd_valid,
  output logic [UPD_AW-1:0] upd_addr,
  output logic              upd_taken,
  input  logic              upd_ready,
  output logic              err,
  output logic [15:0]       branch_cnt,
  output logic [15:0]       mispred_cnt
);

  logic            empty;
  logic            head_taken;
  logic [PC_W-1:0] head_pc, head_target;
  logic            accept, resolve_hit, mispredict_now, push_en;
  logic [PC_W-1:0] correct_pc;

  flush_state_e      state_q, state_d;
  logic              redirect_q;
  logic [PC_W-1:0]   redirect_pc_q;
  logic              upd_valid_q, upd_taken_q;
  logic [UPD_AW-1:0] upd_addr_q;
  logic              err_q;

  assign res_ready      = !upd_valid_q || upd_ready;
  assign accept         = res_valid && res_ready;
  assign resolve_hit    = accept && !empty;
  assign mispredict_now = resolve_hit &&
                          ((res_taken != head_taken) || (res_taken && (res_target != head_target)));
  // Once a mispredict is seen, anything decoded this cycle is wrong-path.
  assign push_en        = pred_valid && !stall && !full && !mispredict_now;
  assign correct_pc     = res_taken ? res_target : head_pc + PC_W'(4);

  br_inflight_fifo #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push_en),
    .push_taken  (pred_taken),
    .push_pc     (pred_pc),
    .push_target (pred_target),
    .pop         (resolve_hit),
    .clear       (mispredict_now),
    .full        (full),
    .empty       (empty),
    .head_taken  (head_taken),
    .head_pc     (head_pc),
    .head_target (head_target)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mispredict_now) state_d = F1;
      F1:      state_d = (FLUSH_CYC > 1) ? F2 : IDLE;
      F2:      state_d = mispredict_now ? F1 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      upd_valid_q   <= 1'b0;
      upd_addr_q    <= '0;
      upd_taken_q   <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q    <= state_d;
      redirect_q <= mispredict_now;
      if (mispredict_now) redirect_pc_q <= correct_pc;
      if (resolve_hit) begin
        upd_valid_q <= 1'b1;
        upd_addr_q  <= head_pc[UPD_AW-1:0];
        upd_taken_q <= res_taken;
      end else if (upd_ready) begin
        upd_valid_q <= 1'b0;
      end
      if (accept && empty) err_q <= 1'b1;
    end
  end

  assign flush       = (state_q != IDLE);
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign upd_valid   = upd_valid_q;
  assign upd_addr    = upd_addr_q;
  assign upd_taken   = upd_taken_q;
  assign err         = err_q;

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [15:0] branch_cnt_q, mispred_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (resolve_hit && (branch_cnt_q != 16'hFFFF))     branch_cnt_q  <= branch_cnt_q + 1'b1;
      if (mispredict_now && (mispred_cnt_q != 16'hFFFF)) mispred_cnt_q <= mispred_cnt_q + 1'b1;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
`else
  assign branch_cnt  = 16'h0000;
  assign mispred_cnt = 16'h0000;
`endif

endmodule
